// File: rtl/interboard_pkg.sv
// rtl/interboard_pkg.sv - shared message layout, pack/unpack helpers and scheduler FSM states
//
// Purpose: one definition of the 22-bit interboard message. The layout from MSB to LSB is
// {move_dir, block_x[4:0], block_y[2:0], msg_type[3:0], card[5:0], sel_len[2:0]}.
// Ports: none (package).
package interboard_pkg;

  localparam int MSG_W = 22;

  localparam int SEL_LEN_LSB  = 0;
  localparam int SEL_LEN_W    = 3;
  localparam int CARD_LSB     = 3;
  localparam int CARD_W       = 6;
  localparam int MSG_TYPE_LSB = 9;
  localparam int MSG_TYPE_W   = 4;
  localparam int BLOCK_Y_LSB  = 13;
  localparam int BLOCK_Y_W    = 3;
  localparam int BLOCK_X_LSB  = 16;
  localparam int BLOCK_X_W    = 5;
  localparam int MOVE_DIR_LSB = 21;

  typedef struct packed {
    logic                  move_dir;
    logic [BLOCK_X_W-1:0]  block_x;
    logic [BLOCK_Y_W-1:0]  block_y;
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [CARD_W-1:0]     card;
    logic [SEL_LEN_W-1:0]  sel_len;
  } msg_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  function automatic msg_t unpack_msg(input logic [MSG_W-1:0] v);
    msg_t m;
    m.move_dir = v[MOVE_DIR_LSB];
    m.block_x  = v[BLOCK_X_LSB  +: BLOCK_X_W];
    m.block_y  = v[BLOCK_Y_LSB  +: BLOCK_Y_W];
    m.msg_type = v[MSG_TYPE_LSB +: MSG_TYPE_W];
    m.card     = v[CARD_LSB     +: CARD_W];
    m.sel_len  = v[SEL_LEN_LSB  +: SEL_LEN_W];
    return m;
  endfunction

  function automatic logic [MSG_W-1:0] pack_msg(input msg_t m);
    logic [MSG_W-1:0] v;
    v = '0;
    v[MOVE_DIR_LSB]                 = m.move_dir;
    v[BLOCK_X_LSB  +: BLOCK_X_W]    = m.block_x;
    v[BLOCK_Y_LSB  +: BLOCK_Y_W]    = m.block_y;
    v[MSG_TYPE_LSB +: MSG_TYPE_W]   = m.msg_type;
    v[CARD_LSB     +: CARD_W]       = m.card;
    v[SEL_LEN_LSB  +: SEL_LEN_W]    = m.sel_len;
    return v;
  endfunction

endpackage

// File: rtl/interboard_tx_scheduler_msg_fifo.sv
// rtl/interboard_tx_scheduler_msg_fifo.sv - synchronous FIFO holding queued port A messages
//
// Purpose: DEPTH-entry FIFO with wrap-bit pointers and a synchronous flush.
// Ports: clk, rst (async, active high); flush empties the FIFO and beats push/pop;
//        push/din write, pop/dout read (dout shows the head combinationally);
//        full, empty, count describe the occupancy after the last edge.
module msg_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/interboard_tx_scheduler.sv
// rtl/interboard_tx_scheduler.sv - arbitrates queued and coalesced messages onto the interboard sender
//
// Purpose: port A messages are queued, port B keeps only its latest update; one message at a
// time is issued with a single ctrl_en pulse while this board holds the transmit turn.
// Ports: clk, rst (async, active high); interboard_rst synchronous flush; transmit link turn;
//        a_en/a_msg/a_full queued requester; b_en/b_msg coalesced requester; send_busy from the
//        sender; ctrl_en + ctrl_* issued message; pending occupancy; overflow, timeout_err sticky.
module interboard_tx_scheduler
  import interboard_pkg::*;
#(
  parameter int A_DEPTH      = 4,
  parameter int STARVE_MAX   = 3,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             interboard_rst,
  input  logic             transmit,
  input  logic             a_en,
  input  logic [MSG_W-1:0] a_msg,
  output logic             a_full,
  input  logic             b_en,
  input  logic [MSG_W-1:0] b_msg,
  input  logic             send_busy,
  output logic             ctrl_en,
  output logic             ctrl_move_dir,
  output logic [4:0]       ctrl_block_x,
  output logic [2:0]       ctrl_block_y,
  output logic [3:0]       ctrl_msg_type,
  output logic [5:0]       ctrl_card,
  output logic [2:0]       ctrl_sel_len,
  output logic [3:0]       pending,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int CW = $clog2(A_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t           state;
  state_t           state_next;
  msg_t             ctrl_q;
  logic [MSG_W-1:0] fifo_dout;
  logic [MSG_W-1:0] b_reg;
  logic [CW:0]      fifo_count;
  logic [SW-1:0]    starve_cnt;
  logic [TW-1:0]    wait_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             b_pend;
  logic             sel_a;
  logic             sel_b;
  logic             busy_expired;

  msg_fifo #(.WIDTH(MSG_W), .DEPTH(A_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (interboard_rst),
    .push  (fifo_push),
    .pop   (sel_a),
    .din   (a_msg),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // B jumps the queue when A is empty or after STARVE_MAX A sends in a row while B waited.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    if (state == IDLE && transmit && !interboard_rst) begin
      if (b_pend && (fifo_empty || starve_cnt == SW'(STARVE_MAX))) sel_b = 1'b1;
      else if (!fifo_empty)                                          sel_a = 1'b1;
    end
  end

  assign fifo_push    = a_en && !interboard_rst && (!fifo_full || sel_a);
  assign busy_expired = (state == WAIT_BUSY) && !send_busy && (wait_cnt == TW'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (sel_a || sel_b) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (send_busy)         state_next = WAIT_DONE;
                 else if (busy_expired) state_next = IDLE;
      WAIT_DONE: if (!send_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (interboard_rst) state_next = IDLE;
  end

  always_comb begin
    ctrl_en = (state == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q      <= '0;
      b_reg       <= '0;
      b_pend      <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else if (interboard_rst) begin
      b_pend      <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (sel_a)      ctrl_q <= unpack_msg(fifo_dout);
      else if (sel_b) ctrl_q <= unpack_msg(b_reg);

      // A fresh update in the dequeue cycle survives: it is newer than what was just issued.
      if (b_en) begin
        b_reg  <= b_msg;
        b_pend <= 1'b1;
      end else if (sel_b) begin
        b_pend <= 1'b0;
      end

      if (sel_b || !b_pend) starve_cnt <= '0;
      else if (sel_a)       starve_cnt <= starve_cnt + 1'b1;

      if (state == ISSUE)          wait_cnt <= '0;
      else if (state == WAIT_BUSY) wait_cnt <= wait_cnt + 1'b1;

      if (a_en && !fifo_push) overflow <= 1'b1;
      if (busy_expired)       timeout_err <= 1'b1;
    end
  end

  assign a_full        = fifo_full;
  assign pending       = 4'(fifo_count) + {3'b000, b_pend};
  assign ctrl_move_dir = ctrl_q.move_dir;
  assign ctrl_block_x  = ctrl_q.block_x;
  assign ctrl_block_y  = ctrl_q.block_y;
  assign ctrl_msg_type = ctrl_q.msg_type;
  assign ctrl_card     = ctrl_q.card;
  assign ctrl_sel_len  = ctrl_q.sel_len;

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// tb/tb_interboard_tx_scheduler.sv - self-checking bench for interboard_tx_scheduler
module tb_interboard_tx_scheduler;
  import interboard_pkg::*;

  localparam int A_DEPTH      = 4;
  localparam int STARVE_MAX   = 3;
  localparam int BUSY_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             interboard_rst = 1'b0;
  logic             transmit = 1'b0;
  logic             a_en = 1'b0;
  logic [MSG_W-1:0] a_msg = '0;
  logic             b_en = 1'b0;
  logic [MSG_W-1:0] b_msg = '0;
  logic             send_busy = 1'b0;
  logic             a_full, ctrl_en, ctrl_move_dir, overflow, timeout_err;
  logic [4:0]       ctrl_block_x;
  logic [2:0]       ctrl_block_y, ctrl_sel_len;
  logic [3:0]       ctrl_msg_type, pending;
  logic [5:0]       ctrl_card;

  interboard_tx_scheduler #(.A_DEPTH(A_DEPTH), .STARVE_MAX(STARVE_MAX), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .transmit(transmit),
    .a_en(a_en), .a_msg(a_msg), .a_full(a_full), .b_en(b_en), .b_msg(b_msg),
    .send_busy(send_busy), .ctrl_en(ctrl_en), .ctrl_move_dir(ctrl_move_dir),
    .ctrl_block_x(ctrl_block_x), .ctrl_block_y(ctrl_block_y), .ctrl_msg_type(ctrl_msg_type),
    .ctrl_card(ctrl_card), .ctrl_sel_len(ctrl_sel_len), .pending(pending),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk(input logic [5:0] card, input logic [3:0] mt);
    msg_t m;
    m.move_dir = card[0];
    m.block_x  = 5'(card + 6'd3);
    m.block_y  = card[2:0];
    m.msg_type = mt;
    m.card     = card;
    m.sel_len  = 3'(card[5:3]);
    return pack_msg(m);
  endfunction

  // Inputs as seen by the clock edge; the model consumes them on the following negedge.
  logic             s_a_en = 1'b0, s_b_en = 1'b0, s_ibr = 1'b0;
  logic [MSG_W-1:0] s_a_msg = '0, s_b_msg = '0;
  always @(posedge clk) begin
    s_a_en  <= a_en;
    s_b_en  <= b_en;
    s_ibr   <= interboard_rst;
    s_a_msg <= a_msg;
    s_b_msg <= b_msg;
  end

  // Transaction model: a queue for A, a latest-value slot for B, a starvation tally.
  logic [MSG_W-1:0] mq[$];
  logic [MSG_W-1:0] issued[$];
  logic [MSG_W-1:0] m_bval = '0, got, exp_msg;
  logic             m_bpend = 1'b0, m_ovf = 1'b0, pend_before, popped_a, have_src;
  int               m_starve = 0, q_before, pulses = 0, cyc = 0, last_pulse = -100;
  bit               model_on = 1'b0;
  msg_t             cm;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (model_on) begin
      if (s_ibr) begin
        mq.delete();
        m_bpend  = 1'b0;
        m_starve = 0;
        m_ovf    = 1'b0;
        check("ibr_no_pulse", ctrl_en, 0);
      end else begin
        q_before    = mq.size();
        pend_before = m_bpend;
        popped_a    = 1'b0;
        if (ctrl_en) begin
          cm = '{ctrl_move_dir, ctrl_block_x, ctrl_block_y, ctrl_msg_type, ctrl_card, ctrl_sel_len};
          got = pack_msg(cm);
          have_src = 1'b1;
          exp_msg  = '0;
          if (m_bpend && (mq.size() == 0 || m_starve == STARVE_MAX)) begin
            exp_msg  = m_bval;
            m_bpend  = 1'b0;
            m_starve = 0;
          end else if (mq.size() != 0) begin
            exp_msg  = mq.pop_front();
            popped_a = 1'b1;
            if (pend_before) m_starve = m_starve + 1;
          end else begin
            have_src = 1'b0;
          end
          check("issue_has_source", have_src, 1);
          if (have_src) check("issue_fields", got, exp_msg);
          check("issue_spacing", (cyc - last_pulse) >= 4, 1);
          issued.push_back(got);
          pulses++;
          last_pulse = cyc;
        end
        if (!pend_before) m_starve = 0;
        if (s_a_en) begin
          if (q_before < A_DEPTH || popped_a) mq.push_back(s_a_msg);
          else m_ovf = 1'b1;
        end
        if (s_b_en) begin
          m_bval  = s_b_msg;
          m_bpend = 1'b1;
        end
      end
      check("pending", pending, mq.size() + int'(m_bpend));
      check("a_full", a_full, mq.size() == A_DEPTH);
      check("overflow", overflow, m_ovf);
    end
  end

  // Sender stand-in: busy for 5 cycles starting the cycle after each pulse.
  bit respond = 1'b1;
  always begin
    @(negedge clk);
    if (ctrl_en && respond) begin
      @(posedge clk); #2 send_busy = 1'b1;
      repeat (5) @(posedge clk);
      #2 send_busy = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_a(input logic [MSG_W-1:0] m);
    a_msg = m; a_en = 1'b1; step(1); a_en = 1'b0;
  endtask

  task automatic push_b(input logic [MSG_W-1:0] m);
    b_msg = m; b_en = 1'b1; step(1); b_en = 1'b0;
  endtask

  task automatic flush_ibr();
    interboard_rst = 1'b1; step(1); interboard_rst = 1'b0;
  endtask

  task automatic wait_pulse(input string name, input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!ctrl_en && n < budget);
    check(name, ctrl_en, 1);
  endtask

  int base, n, k;

  initial begin
    step(3);
    check("rst_ctrl_en", ctrl_en, 0);
    check("rst_pending", pending, 0);
    check("rst_a_full", a_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_card", ctrl_card, 0);
    rst = 1'b0; model_on = 1'b1;
    step(2);

    // Three A messages back to back; first one pins latency and the field layout.
    base = issued.size();
    transmit = 1'b1;
    a_msg = 22'h31B55E; a_en = 1'b1; step(1);
    a_msg = mk(6'h12, 4'h3);
    @(negedge clk);
    check("lat_edge0_ctrl_en", ctrl_en, 0);
    check("lat_edge0_pending", pending, 1);
    step(1);
    a_msg = mk(6'h13, 4'h4);
    @(negedge clk);
    check("lat_edge1_ctrl_en", ctrl_en, 1);
    check("lit_move_dir", ctrl_move_dir, 1);
    check("lit_block_x", ctrl_block_x, 5'h11);
    check("lit_block_y", ctrl_block_y, 3'h5);
    check("lit_msg_type", ctrl_msg_type, 4'hA);
    check("lit_card", ctrl_card, 6'h2B);
    check("lit_sel_len", ctrl_sel_len, 3'h6);
    step(1); a_en = 1'b0;
    step(40);
    check("fifo3_count", issued.size() - base, 3);
    if (issued.size() - base == 3) begin
      check("fifo3_order1", issued[base+1], mk(6'h12, 4'h3));
      check("fifo3_order2", issued[base+2], mk(6'h13, 4'h4));
    end

    // Coalescing: only the last B update goes out.
    transmit = 1'b0;
    base = issued.size();
    push_b(mk(6'h05, 4'h1)); push_b(mk(6'h06, 4'h1)); push_b(mk(6'h07, 4'h1));
    @(negedge clk);
    check("coal_pending", pending, 1);
    step(1); transmit = 1'b1;
    wait_pulse("coal_pulse", 10, n);
    check("coal_card", ctrl_card, 6'h07);
    step(20);
    check("coal_count", issued.size() - base, 1);

    // Starvation bound: A, A, A, B, A.
    transmit = 1'b0;
    base = issued.size();
    for (int i = 1; i <= 4; i++) push_a(mk(6'(i), 4'h2));
    push_b(mk(6'h20, 4'h5));
    transmit = 1'b1;
    step(80);
    check("starve_count", issued.size() - base, 5);
    if (issued.size() - base == 5) begin
      check("starve_o0", issued[base][8:3], 6'h01);
      check("starve_o1", issued[base+1][8:3], 6'h02);
      check("starve_o2", issued[base+2][8:3], 6'h03);
      check("starve_o3", issued[base+3][8:3], 6'h20);
      check("starve_o4", issued[base+4][8:3], 6'h04);
    end

    // Overflow with transmit low.
    transmit = 1'b0;
    for (int i = 0; i < 5; i++) push_a(mk(6'(8'h31 + i), 4'h6));
    @(negedge clk);
    check("ovf_a_full", a_full, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_pending", pending, 4);
    step(1); flush_ibr();
    @(negedge clk);
    check("ovf_cleared", overflow, 0);
    check("ovf_flushed", pending, 0);

    // Busy timeout: no busy from the sender.
    step(1);
    respond = 1'b0; transmit = 1'b1;
    push_a(mk(6'h3A, 4'h7)); push_a(mk(6'h3B, 4'h7));
    wait_pulse("to_first_pulse", 10, n);
    k = 0;
    do begin @(negedge clk); k++; end while (!timeout_err && k < 40);
    check("to_delay", k, 16);
    wait_pulse("to_next_pulse", 10, n);
    check("to_next_delay", n, 1);
    check("to_next_card", ctrl_card, 6'h3B);
    step(25);
    check("to_sticky", timeout_err, 1);
    respond = 1'b1;

    // Interboard reset while WAIT_DONE with two messages queued.
    transmit = 1'b0;
    for (int i = 0; i < 3; i++) push_a(mk(6'(8'h10 + i), 4'h8));
    transmit = 1'b1;
    wait_pulse("ibr_first_pulse", 10, n);
    step(2);
    check("ibr_pre_pending", pending, 2);
    flush_ibr();
    @(negedge clk);
    check("ibr_pending", pending, 0);
    check("ibr_ctrl_en", ctrl_en, 0);
    check("ibr_timeout_clr", timeout_err, 0);
    base = pulses;
    step(20);
    check("ibr_no_more_pulses", pulses - base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
